// File: rtl/conv3_window_gen.sv
// Streaming 3x3 zero-padded window generator (pad 1, stride 1) feeding the depthwise conv3 stage.
// Two line buffers plus a two-column register window; taps outside the image are masked to zero.
module conv3_window_gen #(
  parameter int unsigned CH    = 16,
  parameter int unsigned DW    = 16,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DW-1:0]     in_act,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*9*DW-1:0]   out_act,
  output logic                 frame_done
);

  localparam int unsigned PW = CH * DW;
  localparam int unsigned XW = $clog2(IMG_W + 1);
  localparam int unsigned YW = $clog2(IMG_H + 1);
  localparam int unsigned LW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [PW-1:0]       r_lb1 [IMG_W];
  logic [PW-1:0]       r_lb2 [IMG_W];
  logic [PW-1:0]       r_c0  [3];
  logic [PW-1:0]       r_c1  [3];
  logic                r_out_valid;
  logic                r_frame_done;
  logic [CH*9*DW-1:0]  r_out_act;

  logic                w_x_end;
  logic                w_y_end;
  logic                w_real;
  logic                w_emit;
  logic                w_free;
  logic                w_adv;
  logic                w_last;
  logic [LW-1:0]       w_xi;
  logic [PW-1:0]       w_cur;
  logic [PW-1:0]       w_col [3];
  logic [2:0]          w_row_ok;
  logic [2:0]          w_col_ok;
  logic [PW-1:0]       w_tap [9];
  logic [CH*9*DW-1:0]  w_win;

  assign w_x_end  = (r_x == XW'(IMG_W));
  assign w_y_end  = (r_y == YW'(IMG_H));
  assign w_real   = !w_x_end && !w_y_end;
  assign w_emit   = (r_y != '0) && (r_x != '0);
  assign w_free   = !r_out_valid || out_ready;
  assign in_ready = w_real && (!w_emit || w_free);
  assign w_adv    = (in_valid || !w_real) && (!w_emit || w_free);
  assign w_last   = w_x_end && w_y_end;
  assign w_xi     = w_x_end ? '0 : r_x[LW-1:0];
  assign w_cur    = w_real ? in_act : '0;

  assign w_col[0] = r_lb2[w_xi];
  assign w_col[1] = r_lb1[w_xi];
  assign w_col[2] = w_cur;

  // Bit ky/kx set when source row y-2+ky / column x-2+kx lies inside the image.
  assign w_row_ok = {!w_y_end, r_y >= YW'(1), r_y >= YW'(2)};
  assign w_col_ok = {!w_x_end, r_x >= XW'(1), r_x >= XW'(2)};

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      w_tap[k] = '0;
    end
    for (int ky = 0; ky < 3; ky++) begin
      w_tap[ky*3+0] = (w_row_ok[ky] && w_col_ok[0]) ? r_c0[ky]     : '0;
      w_tap[ky*3+1] = (w_row_ok[ky] && w_col_ok[1]) ? r_c1[ky]     : '0;
      w_tap[ky*3+2] = (w_row_ok[ky] && w_col_ok[2]) ? w_col[ky]    : '0;
    end
  end

  always_comb begin
    w_win = '0;
    for (int c = 0; c < int'(CH); c++) begin
      for (int k = 0; k < 9; k++) begin
        w_win[(c*9 + k)*DW +: DW] = w_tap[k][c*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_out_valid  <= 1'b0;
      r_out_act    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_adv) begin
        if (w_x_end) begin
          r_x <= '0;
          r_y <= w_y_end ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
      if (w_adv && w_emit) begin
        r_out_valid  <= 1'b1;
        r_out_act    <= w_win;
        r_frame_done <= w_last;
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
        r_frame_done <= 1'b0;
      end
    end
  end

  // Line buffers and window columns need no reset: stale contents are always masked.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      for (int ky = 0; ky < 3; ky++) begin
        r_c0[ky] <= r_c1[ky];
        r_c1[ky] <= w_col[ky];
      end
      if (!w_x_end) begin
        r_lb2[w_xi] <= r_lb1[w_xi];
        r_lb1[w_xi] <= w_cur;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_act    = r_out_act;
  assign frame_done = r_frame_done;

endmodule
